// File: rtl/ipif_pkg.sv
// ipif_pkg: shared types and constants for the AXI4-Lite to IPIF bridge.
//   state_t        bridge FSM states
//   OKAY/SLVERR/DECERR  AXI response codes
//   idx_ok()       register-index range check
package ipif_pkg;
    typedef enum logic [2:0] {IDLE, WR_CE, WR_RESP, RD_CE, RD_RESP} state_t;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    function automatic logic idx_ok(input logic [31:0] idx, input int n);
        return idx < 32'(n);
    endfunction
endpackage

// File: rtl/ipif_reset_sync.sv
// ipif_reset_sync: reset-release synchroniser for the downstream IPIF reset.
//   clk     in   clock
//   reset   in   asynchronous active-high reset
//   resetn  out  active-low reset; falls with reset, rises on the 2nd clk edge after release
module ipif_reset_sync (
    input  logic clk,
    input  logic reset,
    output logic resetn
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], 1'b1};
    end
    assign resetn = sync_q[1];
endmodule

// File: rtl/ipif_axil_bridge.sv
// ipif_axil_bridge: AXI4-Lite slave that turns single transfers into IPIF chip-enable cycles.
//   clk, reset                 clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*            AXI4-Lite write address, data and response channels
//   s_axi_ar*/r*               AXI4-Lite read address and data channels
//   IPIF_bus2ip_resetn         synchronised active-low reset for the register decoder
//   IPIF_bus2ip_data/be        latched write data and byte enables
//   IPIF_bus2ip_wrce/rdce      one-hot register chip enables
//   IPIF_ip2bus_data/wrack/rdack  read data and acknowledges from the decoder
module ipif_axil_bridge
    import ipif_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int N_REG              = 2,
    parameter int TIMEOUT_CYCLES     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            IPIF_bus2ip_resetn,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_bus2ip_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] IPIF_bus2ip_be,
    output logic [N_REG-1:0]                IPIF_bus2ip_wrce,
    output logic [N_REG-1:0]                IPIF_bus2ip_rdce,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   IPIF_ip2bus_data,
    input  logic                            IPIF_ip2bus_wrack,
    input  logic                            IPIF_ip2bus_rdack
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                idx_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [1:0]                      resp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]   data_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] be_q;
    logic                            last_rd_q;
    logic [IDX_W-1:0]                wr_idx, rd_idx;
    logic                            wr_ok, rd_ok, pick_wr, wr_acc, rd_acc;
    logic                            in_ce, ce_ack, tmo;
    logic [N_REG-1:0]                ce_vec;
    logic                            unused_addr_lsbs;

    ipif_reset_sync u_reset_sync (
        .clk    (clk),
        .reset  (reset),
        .resetn (IPIF_bus2ip_resetn)
    );

    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
    assign wr_idx  = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx  = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_ok   = idx_ok(32'(wr_idx), N_REG);
    assign rd_ok   = idx_ok(32'(rd_idx), N_REG);
    // On a write/read conflict the grant alternates; last_rd_q resets high so the write goes first.
    assign pick_wr = s_axi_awvalid & s_axi_wvalid & (~s_axi_arvalid | last_rd_q);
    // No address is taken until the downstream decoder is out of reset.
    assign wr_acc  = (state_q == IDLE) & IPIF_bus2ip_resetn & pick_wr;
    assign rd_acc  = (state_q == IDLE) & IPIF_bus2ip_resetn & s_axi_arvalid & ~pick_wr;
    assign in_ce   = (state_q == WR_CE) | (state_q == RD_CE);
    // Acks only count in the matching chip-enable state.
    assign ce_ack  = ((state_q == WR_CE) & IPIF_ip2bus_wrack) | ((state_q == RD_CE) & IPIF_ip2bus_rdack);
    assign tmo     = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    assign ce_vec  = N_REG'(1) << idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = wr_acc ? (wr_ok ? WR_CE : WR_RESP) :
                               rd_acc ? (rd_ok ? RD_CE : RD_RESP) : IDLE;
            WR_CE:   state_d = (ce_ack | tmo) ? WR_RESP : WR_CE;
            WR_RESP: state_d = s_axi_bready ? IDLE : WR_RESP;
            RD_CE:   state_d = (ce_ack | tmo) ? RD_RESP : RD_CE;
            RD_RESP: state_d = s_axi_rready ? IDLE : RD_RESP;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready    = wr_acc;
        s_axi_wready     = wr_acc;
        s_axi_arready    = rd_acc;
        s_axi_bvalid     = state_q == WR_RESP;
        s_axi_rvalid     = state_q == RD_RESP;
        s_axi_bresp      = (state_q == WR_RESP) ? resp_q : OKAY;
        s_axi_rresp      = (state_q == RD_RESP) ? resp_q : OKAY;
        s_axi_rdata      = (state_q == RD_RESP) ? rdata_q : '0;
        IPIF_bus2ip_wrce = (state_q == WR_CE) ? ce_vec : '0;
        IPIF_bus2ip_rdce = (state_q == RD_CE) ? ce_vec : '0;
        IPIF_bus2ip_data = data_q;
        IPIF_bus2ip_be   = be_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            cnt_q     <= '0;
            resp_q    <= OKAY;
            rdata_q   <= '0;
            data_q    <= '0;
            be_q      <= '0;
            last_rd_q <= 1'b1;
        end else begin
            cnt_q <= in_ce ? cnt_q + CNT_W'(1) : '0;
            if (wr_acc) begin
                data_q <= s_axi_wdata;
                be_q   <= s_axi_wstrb;
            end
            if (wr_acc | rd_acc) begin
                idx_q     <= wr_acc ? wr_idx : rd_idx;
                resp_q    <= (wr_acc ? wr_ok : rd_ok) ? OKAY : DECERR;
                rdata_q   <= '0;
                last_rd_q <= rd_acc;
            end
            if (in_ce & ~ce_ack & tmo) resp_q <= SLVERR;
            if ((state_q == RD_CE) & IPIF_ip2bus_rdack) rdata_q <= IPIF_ip2bus_data;
        end
    end
endmodule

// File: tb/tb_ipif_axil_bridge.sv
// tb_ipif_axil_bridge: table-driven, scoreboarded bench for ipif_axil_bridge.
module tb_ipif_axil_bridge;
    import ipif_pkg::*;

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          dly;
        logic [31:0] ack_data;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [1:0]  ce;
        int          ce_n;
    } vec_t;

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_axi_awaddr, s_axi_araddr;
    logic        s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready;
    logic        s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0]  s_axi_wstrb;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic        IPIF_bus2ip_resetn;
    logic [31:0] IPIF_bus2ip_data, IPIF_ip2bus_data;
    logic [3:0]  IPIF_bus2ip_be;
    logic [1:0]  IPIF_bus2ip_wrce, IPIF_bus2ip_rdce;
    logic        IPIF_ip2bus_wrack, IPIF_ip2bus_rdack;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    vec_t        tbl[8];
    logic [31:0] last_wd = '0;
    logic [3:0]  last_be = '0;

    bit          ack_en = 1'b0;
    int          ack_dly = 0;
    logic [31:0] ack_data = '0;
    bit          stray = 1'b0;
    logic [31:0] stray_data = '0;
    int          ce_run = 0;

    ipif_axil_bridge #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (8),
        .N_REG              (2),
        .TIMEOUT_CYCLES     (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .s_axi_awaddr       (s_axi_awaddr),
        .s_axi_awvalid      (s_axi_awvalid),
        .s_axi_awready      (s_axi_awready),
        .s_axi_wdata        (s_axi_wdata),
        .s_axi_wstrb        (s_axi_wstrb),
        .s_axi_wvalid       (s_axi_wvalid),
        .s_axi_wready       (s_axi_wready),
        .s_axi_bresp        (s_axi_bresp),
        .s_axi_bvalid       (s_axi_bvalid),
        .s_axi_bready       (s_axi_bready),
        .s_axi_araddr       (s_axi_araddr),
        .s_axi_arvalid      (s_axi_arvalid),
        .s_axi_arready      (s_axi_arready),
        .s_axi_rdata        (s_axi_rdata),
        .s_axi_rresp        (s_axi_rresp),
        .s_axi_rvalid       (s_axi_rvalid),
        .s_axi_rready       (s_axi_rready),
        .IPIF_bus2ip_resetn (IPIF_bus2ip_resetn),
        .IPIF_bus2ip_data   (IPIF_bus2ip_data),
        .IPIF_bus2ip_be     (IPIF_bus2ip_be),
        .IPIF_bus2ip_wrce   (IPIF_bus2ip_wrce),
        .IPIF_bus2ip_rdce   (IPIF_bus2ip_rdce),
        .IPIF_ip2bus_data   (IPIF_ip2bus_data),
        .IPIF_ip2bus_wrack  (IPIF_ip2bus_wrack),
        .IPIF_ip2bus_rdack  (IPIF_ip2bus_rdack)
    );

    always #5 clk = ~clk;

    // Register-decoder model: acks the ack_dly-th chip-enable cycle (0 = first one).
    initial begin
        IPIF_ip2bus_wrack = 1'b0;
        IPIF_ip2bus_rdack = 1'b0;
        IPIF_ip2bus_data  = '0;
        forever begin
            @(negedge clk);
            if ((IPIF_bus2ip_wrce != 0) || (IPIF_bus2ip_rdce != 0)) begin
                IPIF_ip2bus_wrack = ack_en && (ce_run == ack_dly) && (IPIF_bus2ip_wrce != 0);
                IPIF_ip2bus_rdack = ack_en && (ce_run == ack_dly) && (IPIF_bus2ip_rdce != 0);
                IPIF_ip2bus_data  = (ack_en && ce_run == ack_dly) ? ack_data : $urandom;
                ce_run++;
            end else begin
                ce_run = 0;
                IPIF_ip2bus_wrack = stray;
                IPIF_ip2bus_rdack = stray;
                IPIF_ip2bus_data  = stray ? stray_data : $urandom;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_chk(input string name);
        chk(name, {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                   s_axi_bresp, s_axi_rresp, s_axi_rdata, IPIF_bus2ip_resetn, IPIF_bus2ip_data,
                   IPIF_bus2ip_be, IPIF_bus2ip_wrce, IPIF_bus2ip_rdce}, '0);
    endtask

    // Called at a sample point where bvalid/rvalid is high: score it, then handshake.
    task automatic take_resp(input bit is_wr);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow: unexpected %s response", is_wr ? "write" : "read");
        end else begin
            e = sb_q.pop_front();
            chk("sb_type", is_wr, e.is_wr);
            chk("sb_resp", is_wr ? s_axi_bresp : s_axi_rresp, e.resp);
            if (!is_wr) chk("sb_rdata", s_axi_rdata, e.rdata);
        end
        if (is_wr) s_axi_bready = 1'b1;
        else       s_axi_rready = 1'b1;
        #1 chk("resp_no_accept", {s_axi_awready, s_axi_arready}, 2'b00);
        @(posedge clk);
        #1;
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_resp(input bit is_wr);
        bit done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            #1;
            if (is_wr ? s_axi_bvalid : s_axi_rvalid) begin
                done = 1'b1;
                take_resp(is_wr);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: no %s response within 40 cycles", is_wr ? "write" : "read");
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   ce_n = 0;
        int   lat = 0;
        bit   done = 1'b0;
        logic [1:0] ce, other;
        ack_en   = v.dly >= 0;
        ack_dly  = v.dly;
        ack_data = v.ack_data;
        sb_q.push_back('{v.is_wr, v.resp, v.rdata});
        @(negedge clk);
        if (v.is_wr) begin
            s_axi_awaddr  = v.addr;
            s_axi_wdata   = v.data;
            s_axi_wstrb   = v.strb;
            s_axi_awvalid = 1'b1;
            s_axi_wvalid  = 1'b1;
        end else begin
            s_axi_araddr  = v.addr;
            s_axi_arvalid = 1'b1;
        end
        #1 chk($sformatf("v%0d_accept", idx), {s_axi_awready, s_axi_wready, s_axi_arready},
               v.is_wr ? 3'b110 : 3'b001);
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            #1;
            ce    = v.is_wr ? IPIF_bus2ip_wrce : IPIF_bus2ip_rdce;
            other = v.is_wr ? IPIF_bus2ip_rdce : IPIF_bus2ip_wrce;
            if (other != 0) chk($sformatf("v%0d_other_ce", idx), other, 2'b00);
            if (ce != 0) begin
                ce_n++;
                chk($sformatf("v%0d_ce_onehot", idx), ce, v.ce);
                if (v.is_wr) chk($sformatf("v%0d_bus_data", idx), {IPIF_bus2ip_be, IPIF_bus2ip_data}, {v.strb, v.data});
            end
            if (v.is_wr ? s_axi_bvalid : s_axi_rvalid) begin
                lat  = k;
                done = 1'b1;
                take_resp(v.is_wr);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL v%0d_resp_timeout: no response within 40 cycles", idx);
        end
        chk($sformatf("v%0d_ce_cycles", idx), ce_n, v.ce_n);
        chk($sformatf("v%0d_latency", idx), lat, v.ce_n + 1);
        if (v.is_wr) begin
            last_wd = v.data;
            last_be = v.strb;
        end else begin
            chk($sformatf("v%0d_bus_hold", idx), {IPIF_bus2ip_be, IPIF_bus2ip_data}, {last_be, last_wd});
        end
    endtask

    initial begin
        bit bseen;
        //            wr  addr   wdata         strb  dly  ack_data      resp    rdata         ce     ce_n
        tbl[0] = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF,  1, 32'h0,        OKAY,   32'h0,        2'b10,  2};
        tbl[1] = '{1'b0, 8'h00, 32'h0,        4'h0,  2, 32'h12345678, OKAY,   32'h12345678, 2'b01,  3};
        tbl[2] = '{1'b1, 8'h08, 32'h01020304, 4'h3,  0, 32'h0,        DECERR, 32'h0,        2'b00,  0};
        tbl[3] = '{1'b0, 8'hFC, 32'h0,        4'h0,  0, 32'hFFFFFFFF, DECERR, 32'h0,        2'b00,  0};
        tbl[4] = '{1'b0, 8'h04, 32'h0,        4'h0, -1, 32'h0,        SLVERR, 32'h0,        2'b10, 16};
        tbl[5] = '{1'b1, 8'h00, 32'hA5A5A5A5, 4'h9, -1, 32'h0,        SLVERR, 32'h0,        2'b01, 16};
        tbl[6] = '{1'b1, 8'h07, 32'h0000FFFF, 4'h5,  0, 32'h0,        OKAY,   32'h0,        2'b10,  1};
        tbl[7] = '{1'b0, 8'h05, 32'h0,        4'h0, 15, 32'h89ABCDEF, OKAY,   32'h89ABCDEF, 2'b10, 16};

        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 zero_chk("reset_outputs");
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("resetn_edge1", IPIF_bus2ip_resetn, 1'b0);
        @(posedge clk);
        #1 chk("resetn_edge2", IPIF_bus2ip_resetn, 1'b1);

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Conflicts: write first after reset, then alternating grants.
        ack_en = 1'b1; ack_dly = 0; ack_data = 32'h55AA55AA;
        sb_q.push_back('{1'b1, OKAY, 32'h0});
        sb_q.push_back('{1'b0, OKAY, 32'h55AA55AA});
        @(negedge clk);
        s_axi_awaddr = 8'h00; s_axi_wdata = 32'h11111111; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        s_axi_araddr = 8'h04; s_axi_arvalid = 1'b1;
        #1 chk("arb1_grant", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b110);
        @(posedge clk);
        #1 begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
        wait_resp(1'b1);
        sb_q.push_back('{1'b1, OKAY, 32'h0});
        @(negedge clk);
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'h22222222;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        #1 chk("arb2_grant", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b001);
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
        wait_resp(1'b0);
        @(negedge clk);
        #1 chk("arb2_wr_next", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b110);
        @(posedge clk);
        #1 begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
        wait_resp(1'b1);
        sb_q.push_back('{1'b0, OKAY, 32'h55AA55AA});
        sb_q.push_back('{1'b1, OKAY, 32'h0});
        @(negedge clk);
        s_axi_awaddr = 8'h00; s_axi_wdata = 32'h33333333;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        #1 chk("arb3_grant", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b001);
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
        wait_resp(1'b0);
        @(negedge clk);
        #1 chk("arb3_wr_next", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b110);
        @(posedge clk);
        #1 begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
        wait_resp(1'b1);
        last_wd = 32'h33333333; last_be = 4'hF;

        // Held read response with stray acks and a pending AR behind it.
        ack_data = 32'hCAFEF00D;
        sb_q.push_back('{1'b0, OKAY, 32'hCAFEF00D});
        @(negedge clk);
        s_axi_araddr = 8'h00; s_axi_arvalid = 1'b1;
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
        bseen = 1'b0;
        for (int k = 0; k < 10 && !bseen; k++) begin
            @(negedge clk);
            #1 bseen = s_axi_rvalid;
        end
        chk("hold_rvalid_seen", bseen, 1'b1);
        stray = 1'b1; stray_data = 32'h0BADBEEF;
        s_axi_araddr = 8'hF0; s_axi_arvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk($sformatf("hold_stable_%0d", k), {s_axi_rvalid, s_axi_rresp, s_axi_rdata, s_axi_arready},
                   {1'b1, OKAY, 32'hCAFEF00D, 1'b0});
        end
        take_resp(1'b0);
        sb_q.push_back('{1'b0, DECERR, 32'h0});
        @(negedge clk);
        #1 chk("pending_ar_accept", s_axi_arready, 1'b1);
        @(posedge clk);
        #1 s_axi_arvalid = 1'b0;
        wait_resp(1'b0);
        stray = 1'b0;

        // Reset in the middle of a write chip-enable cycle.
        ack_en = 1'b0;
        @(negedge clk);
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'h13572468; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(posedge clk);
        #1 begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; end
        @(negedge clk);
        #1 chk("rst_pre_wrce", IPIF_bus2ip_wrce, 2'b10);
        #2 reset = 1'b1;
        #1 zero_chk("rst_mid_outputs");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bseen = 1'b0;
        @(posedge clk);
        #1 chk("rst_resetn_edge1", IPIF_bus2ip_resetn, 1'b0);
        bseen = bseen | s_axi_bvalid;
        @(posedge clk);
        #1 chk("rst_resetn_edge2", IPIF_bus2ip_resetn, 1'b1);
        repeat (6) begin
            @(negedge clk);
            bseen = bseen | s_axi_bvalid;
        end
        chk("rst_no_bvalid", bseen, 1'b0);
        chk("rst_sb_empty", sb_q.size(), 0);
        last_wd = '0; last_be = '0;
        run_vec(tbl[0], 8);
        run_vec(tbl[1], 9);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
